// File: rtl/codec_ctrl_serializer.sv
// codec_ctrl_serializer: buffers codec register writes in a small FIFO and
// shifts each one out MSB first on an SPI mode-0 control port as a
// {addr[3:0], data[23:0]} frame.
// Optional feature macro: CODEC_SER_PARITY_EN appends an even-parity bit
// after data[0], which makes the frame 29 bits long.
module codec_ctrl_serializer #(
    parameter int FIFO_DEPTH = 4,   // buffered frames, power of 2, >= 2
    parameter int CLK_DIV    = 2,   // clk cycles per sclk half-period, >= 1
    parameter int GAP_CYCLES = 4    // min clk cycles of csn high between frames
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        codec_ce,
    input  logic [3:0]  codec_addr,
    input  logic [23:0] codec_data,
    output logic        spi_sclk,
    output logic        spi_csn,
    output logic        spi_mosi,
    output logic        busy,
    output logic        overflow
);

    localparam int WORD_W = 28;
`ifdef CODEC_SER_PARITY_EN
    localparam int FRAME_W = WORD_W + 1;
`else
    localparam int FRAME_W = WORD_W;
`endif
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int DIV_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(DIV_MAX + 1);
    localparam int BW      = $clog2(FRAME_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_HOLD,
        S_GAP
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [WORD_W-1:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    logic [AW:0]         w_count;
    logic [AW:0]         w_count_next;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [WORD_W-1:0]   w_pop_word;
    logic [FRAME_W-1:0]  w_load_frame;

    logic [FRAME_W-1:0]  r_shift;
    logic [CW-1:0]       r_div_cnt;
    logic [BW-1:0]       r_bit_cnt;
    logic                w_div_last;
    logic                w_gap_last;
    logic                w_last_bit;
    logic                w_in_frame;

    logic                r_busy;
    logic                r_overflow;

    // FIFO occupancy and handshake. Pointers carry one extra wrap bit so
    // full and empty are distinguishable without a separate counter.
    assign w_count      = r_wr_ptr - r_rd_ptr;
    assign w_empty      = (w_count == '0);
    assign w_full       = (w_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop        = (r_state == S_IDLE) && !w_empty;
    // A pop in the same cycle frees a slot, so a write to a full FIFO still
    // lands when the serializer is taking a word out.
    assign w_push       = codec_ce && (!w_full || w_pop);
    assign w_drop       = codec_ce && w_full && !w_pop;
    assign w_count_next = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_pop_word   = r_mem[r_rd_ptr[AW-1:0]];

`ifdef CODEC_SER_PARITY_EN
    assign w_load_frame = {w_pop_word, ^w_pop_word};
`else
    assign w_load_frame = w_pop_word;
`endif

    assign w_div_last = (r_div_cnt == CW'(CLK_DIV - 1));
    assign w_gap_last = (r_div_cnt == CW'(GAP_CYCLES - 1));
    assign w_last_bit = (r_bit_cnt == BW'(FRAME_W - 1));

    // FIFO pointers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // the pre-edge values of its inputs, independent of statement order.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; stale words are unreachable
        // because the pointers reset, and leaving it out keeps it a plain RAM.
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {codec_addr, codec_data};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and
        // no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (!w_empty)  w_state_next = S_SHIFT_LO;
            S_SHIFT_LO: if (w_div_last) w_state_next = S_SHIFT_HI;
            S_SHIFT_HI: if (w_div_last) w_state_next = w_last_bit ? S_HOLD : S_SHIFT_LO;
            S_HOLD:     if (w_div_last) w_state_next = S_GAP;
            S_GAP:      if (w_gap_last) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: decoded from registered state, so they never glitch
    // relative to clk. mosi is forced low outside a frame.
    always_comb begin
        w_in_frame = (r_state == S_SHIFT_LO) || (r_state == S_SHIFT_HI) ||
                     (r_state == S_HOLD);
        spi_sclk   = (r_state == S_SHIFT_HI);
        spi_csn    = !w_in_frame;
        spi_mosi   = w_in_frame ? r_shift[FRAME_W-1] : 1'b0;
    end

    // Shared divider, bit counter and shift register. The divider restarts
    // on every state change; the shift only advances on the sclk falling
    // transition so mosi is stable across each high phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (r_state == S_IDLE || w_state_next != r_state) r_div_cnt <= '0;
            else                                               r_div_cnt <= r_div_cnt + CW'(1);

            if (w_pop) begin
                r_shift   <= w_load_frame;
                r_bit_cnt <= '0;
            end else if (r_state == S_SHIFT_HI && w_div_last && !w_last_bit) begin
                r_shift   <= r_shift << 1;
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end
        end
    end

    // Status flags: busy looks one cycle ahead so it is registered yet
    // drops exactly when the FSM returns to IDLE with nothing queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_busy <= (w_count_next != '0) || (w_state_next != S_IDLE);
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign busy     = r_busy;
    assign overflow = r_overflow;

endmodule

// File: doc/codec_ctrl_serializer.md
Name: codec_ctrl_serializer

Overview:
- Downstream consumer of the codec MMU write strobe (codec_ce, codec_addr, codec_data).
- Buffers each codec register write in a small FIFO.
- Serialises each write, MSB first, onto the audio codec's SPI-style control port (mode 0) as a 28-bit frame: 4-bit address followed by 24-bit data.
- The CPU can issue back-to-back writes without waiting for the slow serial link.

Parameters:
- FIFO_DEPTH, 4, number of buffered frames; power of 2, minimum 2.
- CLK_DIV, 2, clk cycles per SCLK half-period; minimum 1.
- GAP_CYCLES, 4, minimum clk cycles csn stays high between frames; minimum 1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- codec_ce  input  1  write strobe; one push per high cycle.
- codec_addr  input  4  codec register address.
- codec_data  input  24  codec register data.
- spi_sclk  output  1  serial clock; idles low.
- spi_csn  output  1  frame select, active low.
- spi_mosi  output  1  serial data.
- busy  output  1  high while the FIFO is non-empty or the FSM is not in IDLE.
- overflow  output  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Reset values (rst high at a clk edge): spi_sclk=0, spi_csn=1, spi_mosi=0, busy=0, overflow=0. FIFO pointers cleared. FSM=IDLE.
- Reset mid-frame aborts the frame: csn is high on the cycle after rst is sampled. The partial frame and all FIFO contents are discarded.
- Push: when codec_ce=1 and the FIFO is not full, {codec_addr, codec_data} is written at the end of that cycle.
- Full FIFO:
  - A write is dropped and overflow sets, unless a pop occurs in the same cycle; then the push is accepted.
  - overflow clears only on rst.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP. A single divider counter counts CLK_DIV or GAP_CYCLES.
- IDLE:
  - If the FIFO is non-empty at cycle T, pop into the 28-bit shift register.
  - At T+1: csn=0, sclk=0, mosi=frame[27]. Go to SHIFT_LO.
  - A push in cycle T becomes poppable at T+1 at the earliest.
- SHIFT_LO: after CLK_DIV cycles, sclk goes to 1 and the FSM enters SHIFT_HI. The codec samples on this rising edge.
- SHIFT_HI, after CLK_DIV cycles:
  - Remaining bits: sclk=0, shift left so mosi shows the next bit, enter SHIFT_LO.
  - After the 28th bit: sclk=0, enter HOLD.
- HOLD: CLK_DIV cycles with csn low, then csn=1, mosi=0, enter GAP.
- GAP: GAP_CYCLES cycles, then IDLE. A new pop can occur in the first IDLE cycle.
- Frame timing, relative to csn falling at T+1:
  - Bit k (k=0..27) rises at T+1+(2k+1)*CLK_DIV.
  - csn rises at T+1+57*CLK_DIV.
- Frame bit order: codec_addr[3] first, codec_data[0] last.
- mosi changes only on sclk falling transitions, or when csn falls. It is stable for the whole of each sclk-high phase.
- A codec_ce arriving during a frame never disturbs the frame in flight.
- busy is registered. It is high from the cycle after a push until the cycle after GAP ends with the FIFO empty.

Optional Feature:
- Macro: CODEC_SER_PARITY_EN.
- Defined:
  - An even-parity bit over the 28 address/data bits is appended after codec_data[0].
  - Frame is 29 bits; csn rises at T+1+59*CLK_DIV.
- Undefined: 28-bit frame with no parity logic. Timing is as above.

Test Plan:
- Single write, CLK_DIV=2: codec_addr=4'h3, codec_data=24'hA5C3F0 -> csn low for 114 cycles; the 28 bits sampled on rising sclk equal 28'h3A5C3F0; sclk idles 0; mosi stable while sclk=1; busy returns to 0 after the gap.
- Burst overflow, FIFO_DEPTH=4, FSM idle: six codec_ce pulses in consecutive cycles T..T+5 -> first write popped at T+1; next four buffered; sixth dropped; overflow=1 from T+6; exactly five frames emitted in order.
- Push during pop while full: FIFO full and a pop in the same cycle as codec_ce=1 -> push accepted; overflow stays 0.
- Inter-frame gap, GAP_CYCLES=4: two queued writes -> at least 4 clk cycles of csn=1 between frames; second frame data correct.
- Mid-frame reset: rst pulsed during bit 10 of a frame with two more frames queued -> the cycle after, csn=1, sclk=0, busy=0; no further frames emitted; overflow=0.
- With CODEC_SER_PARITY_EN: addr 4'h1, data 24'h000001 (two ones) -> 29th bit 0. With data 24'h000003 -> 29th bit 1; csn low for 59*CLK_DIV cycles.
